multichannel_network_interface: RTL
===================================

# multichannel_network_interface

Single-clock, parametrised network interface that replaces the dual-clock single-queue NI between the RISC-V core's AXI4-Lite port and the NoC router local port. It carries NUM_CH independent packet channels, each with its own TX and RX FIFO, and arbitrates TX traffic onto the router round-robin. It presents per-channel status, a maskable level interrupt and sticky error flags to software through a small register map. SWNET and LWNET map to channel data-register writes and reads.

## Interface
- NUM_CH, 4: number of channels, 1..8.
- PKT_WIDTH, 32: packet width, 8..32; AXI data is 32-bit, packets occupy bits [PKT_WIDTH-1:0], upper read bits are zero.
- FIFO_DEPTH, 4: entries per FIFO, a power of two, ≥2.
- Ports: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- axi_awaddr  in  32  write address; only [7:2] are decoded.
- axi_awvalid/axi_awready  in/out  1  AW handshake.
- axi_wdata  in  32, axi_wstrb  in  4, axi_wvalid/axi_wready  in/out  1  W channel; wstrb is ignored, full-word writes only.
- axi_bresp  out  2, axi_bvalid  out  1, axi_bready  in  1  write response.
- axi_araddr  in  32, axi_arvalid/axi_arready  in/out  1  read address.
- axi_rdata  out  32, axi_rresp  out  2, axi_rvalid  out  1, axi_rready  in  1  read data.
- net_tx_packet  out  PKT_WIDTH, net_tx_channel  out  3, net_tx_valid  out  1, net_tx_ready  in  1  router inject.
- net_rx_packet  in  PKT_WIDTH, net_rx_channel  in  3, net_rx_valid  in  1, net_rx_ready  out  1  router eject.
- cpu_interrupt  out  1  level interrupt.

## Operation
- **Register map** (byte offsets):
  - 0x00+4c: CHc_DATA. Write pushes into TX FIFO c. Read pops RX FIFO c.
  - 0x40 STATUS (RO): [7:0] rx_nonempty, [15:8] tx_full, [23:16] rx_overflow (sticky).
  - 0x44 IRQ_MASK (RW): [7:0].
  - 0x48 IRQ_CLEAR (W1C): [7:0] clears rx_overflow.
  - 0x4C DROP_CNT (RO).
  - Any other offset, or c ≥ NUM_CH, is unmapped.
- **Write path**:
  - axi_awready = axi_wready = axi_awvalid & axi_wvalid & ~axi_bvalid. AW and W are accepted together, never separately.
  - A write to CHc_DATA with TX FIFO c full is dropped and answered with SLVERR (2'b10).
  - Unmapped writes and writes to RO registers return SLVERR with no side effect. Everything else returns OKAY.
- **Read path**:
  - axi_arready = ~axi_rvalid.
  - A read of CHc_DATA pops RX FIFO c at the accept edge.
  - A read of an empty RX FIFO returns rdata 0 with SLVERR. Unmapped reads return 0 with SLVERR.
- **TX arbiter**:
  - Round-robin over non-empty TX FIFOs, starting after the last-granted channel. After reset, the search starts at channel 0.
  - The output register holds packet and channel stable while net_tx_valid & ~net_tx_ready.
  - The register reloads only on transfer (valid & ready) or when empty. The next grant may be issued in the same cycle as a transfer, giving back-to-back throughput of 1 packet/cycle.
- **RX**:
  - Without the drop feature: net_rx_ready = (net_rx_channel < NUM_CH) & ~rx_full[net_rx_channel], computed combinationally.
  - A push occurs on valid & ready.
- **Interrupt**: cpu_interrupt is registered, equal to |((rx_nonempty | rx_overflow) & IRQ_MASK).
- **Simultaneous events**:
  - For a full FIFO, ready/full is evaluated on pre-edge state. A push is blocked even when a pop occurs in the same cycle.
  - For an empty FIFO, a same-cycle push and pop gives the pop SLVERR; the pushed entry remains.
  - A W1C in the same cycle as an overflow event leaves the bit set.

## Timing
- All outputs reset to 0: the ready signals, valids, resp, rdata, net_tx_*, net_rx_ready and cpu_interrupt. All FIFOs, pointers, sticky bits, mask and counter also reset to 0.
- rst mid-operation flushes all FIFOs. In-flight AXI responses are discarded.
- axi_bvalid/axi_rvalid assert the cycle after accept and hold until bready/rready.
- TX latency: the write accepted at edge E0 fills the FIFO. net_tx_valid rises after E1 if the arbiter grants that channel.
- RX latency: a push at edge E0 sets STATUS.rx_nonempty after E0. cpu_interrupt rises after E1.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.

## Configuration
- NI_RX_DROP_EN defined:
  - net_rx_ready = 1 whenever not in reset.
  - A packet to a full RX FIFO, or to a channel ≥ NUM_CH, is dropped and sets rx_overflow[min(ch,7)].
  - DROP_CNT is a 16-bit counter that increments on each drop and saturates at 0xFFFF. It is cleared only by rst.
- NI_RX_DROP_EN undefined:
  - Backpressure via net_rx_ready as above.
  - rx_overflow stays 0. A DROP_CNT read returns 0 with SLVERR.

## Structure
- Package ni_pkg holds:
  - register offset localparams;
  - RESP_OKAY/RESP_SLVERR;
  - the channel field width (3);
  - the STATUS bit-field positions.
- Sub-module ni_sync_fifo: a parametrised width/depth single-clock FIFO with push, pop, full, empty and head outputs. It is instantiated 2×NUM_CH times.
- Arbiter and register decode live in the top module.

## Test plan
- Write 0x12345678 to 0x04 with net_tx_ready=1. Expect net_tx_packet=0x12345678, net_tx_channel=1 and net_tx_valid two cycles after accept; bresp=OKAY.
- Fill TX FIFO ch0 with 4 writes while net_tx_ready=0. The 5th write must return bresp=SLVERR. Releasing ready then emits exactly the 4 packets in order.
- Preload ch0, ch1 and ch2 with 2 packets each, then raise net_tx_ready. Expect channel order 0,1,2,0,1,2.
- Set IRQ_MASK=0x04, then inject 0xABCDEF01 on ch2. Expect cpu_interrupt=1; a read of 0x08 returns 0xABCDEF01 with OKAY; the interrupt drops; a second read returns 0 with SLVERR.
- Inject 5 packets into ch3 without reads.
  - Without NI_RX_DROP_EN: net_rx_ready=0 on the 5th packet.
  - With NI_RX_DROP_EN: STATUS[19]=1 and DROP_CNT=1. Writing 0x08 to IRQ_CLEAR clears the bit.
- Assert rst for one cycle with TX and RX FIFOs non-empty. Afterwards all outputs are 0 and STATUS reads 0x00000000.

Source files
------------

// File: rtl/ni_pkg.sv
// Shared definitions for the multichannel network interface: register offsets,
// AXI response codes, channel field width and STATUS bit-field positions.
package ni_pkg;

  localparam int CH_W = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [7:0] OFF_STATUS    = 8'h40;
  localparam logic [7:0] OFF_IRQ_MASK  = 8'h44;
  localparam logic [7:0] OFF_IRQ_CLEAR = 8'h48;
  localparam logic [7:0] OFF_DROP_CNT  = 8'h4C;

  localparam int ST_RX_NONEMPTY = 0;
  localparam int ST_TX_FULL     = 8;
  localparam int ST_RX_OVERFLOW = 16;

endpackage

// File: rtl/ni_sync_fifo.sv
// Single-clock FIFO, extra pointer bit separates full/empty; head visible combinationally.
// Push while full or pop while empty is ignored; flags are pre-edge state only.
module ni_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] head_next,
  output logic             full,
  output logic             empty,
  output logic             multi
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      rd_ptr_nx;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];

  assign count     = wr_ptr - rd_ptr;
  assign rd_ptr_nx = rd_ptr + ONE;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign multi     = count > ONE;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign head_next = mem[rd_ptr_nx[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + ONE;
      if (pop && !empty) rd_ptr <= rd_ptr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/multichannel_network_interface.sv
// AXI4-Lite fronted NI: NUM_CH TX/RX FIFO pairs, round-robin TX arbiter, STATUS/IRQ registers.
// Optional NI_RX_DROP_EN: RX never backpressures, drops set sticky rx_overflow and count in DROP_CNT.
module multichannel_network_interface
  import ni_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int PKT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          axi_awaddr,
  input  logic                 axi_awvalid,
  output logic                 axi_awready,
  input  logic [31:0]          axi_wdata,
  input  logic [3:0]           axi_wstrb,
  input  logic                 axi_wvalid,
  output logic                 axi_wready,
  output logic [1:0]           axi_bresp,
  output logic                 axi_bvalid,
  input  logic                 axi_bready,
  input  logic [31:0]          axi_araddr,
  input  logic                 axi_arvalid,
  output logic                 axi_arready,
  output logic [31:0]          axi_rdata,
  output logic [1:0]           axi_rresp,
  output logic                 axi_rvalid,
  input  logic                 axi_rready,
  output logic [PKT_WIDTH-1:0] net_tx_packet,
  output logic [CH_W-1:0]      net_tx_channel,
  output logic                 net_tx_valid,
  input  logic                 net_tx_ready,
  input  logic [PKT_WIDTH-1:0] net_rx_packet,
  input  logic [CH_W-1:0]      net_rx_channel,
  input  logic                 net_rx_valid,
  output logic                 net_rx_ready,
  output logic                 cpu_interrupt
);

  localparam logic [5:0] NUM_CH_W = 6'(NUM_CH);
  localparam logic [3:0] NUM_CH_C = 4'(NUM_CH);

  logic [NUM_CH-1:0]    tx_push, tx_pop, tx_full, tx_empty, tx_multi, tx_avail;
  logic [NUM_CH-1:0]    rx_push, rx_pop, rx_full, rx_empty, rx_multi_unused;
  logic [PKT_WIDTH-1:0] tx_head [NUM_CH];
  logic [PKT_WIDTH-1:0] tx_head2 [NUM_CH];
  logic [PKT_WIDTH-1:0] tx_cand [NUM_CH];
  logic [PKT_WIDTH-1:0] rx_head [NUM_CH];
  logic [PKT_WIDTH-1:0] rx_head2_unused [NUM_CH];
  logic [7:0]           tx_full8, rx_full8, rx_nonempty8, rx_overflow, irq_mask;
  logic [15:0]          drop_cnt;
  logic [31:0]          status_w, rd_dat;
  logic [1:0]           wr_resp, rd_resp;
  logic                 aw_hs, ar_hs, wr_is_ch, rd_is_ch, mask_we, clr_we, rx_ch_ok;
  logic [7:0]           wr_off, rd_off;
  logic [2:0]           wr_ch, rd_ch, arb_ch, rr_start;
  logic                 tx_xfer, arb_load, arb_found;
  logic [PKT_WIDTH-1:0] arb_pkt;
  logic                 unused_ok;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ni_sync_fifo #(.WIDTH(PKT_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push[c]), .push_dat(axi_wdata[PKT_WIDTH-1:0]),
      .pop(tx_pop[c]), .head(tx_head[c]), .head_next(tx_head2[c]),
      .full(tx_full[c]), .empty(tx_empty[c]), .multi(tx_multi[c])
    );
    ni_sync_fifo #(.WIDTH(PKT_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push[c]), .push_dat(net_rx_packet),
      .pop(rx_pop[c]), .head(rx_head[c]), .head_next(rx_head2_unused[c]),
      .full(rx_full[c]), .empty(rx_empty[c]), .multi(rx_multi_unused[c])
    );
  end

  always_comb begin
    tx_full8                  = '0;
    rx_full8                  = '0;
    rx_nonempty8              = '0;
    tx_full8[NUM_CH-1:0]      = tx_full;
    rx_full8[NUM_CH-1:0]      = rx_full;
    rx_nonempty8[NUM_CH-1:0]  = ~rx_empty;
    status_w                  = '0;
    status_w[ST_RX_NONEMPTY +: 8] = rx_nonempty8;
    status_w[ST_TX_FULL +: 8]     = tx_full8;
    status_w[ST_RX_OVERFLOW +: 8] = rx_overflow;
  end

  // ---------------- RX ingress ----------------
  assign rx_ch_ok = {1'b0, net_rx_channel} < NUM_CH_C;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      rx_push[c] = net_rx_valid && net_rx_ready && (net_rx_channel == 3'(c)) && !rx_full[c];
    end
  end

`ifdef NI_RX_DROP_EN
  localparam bit DROP_EN = 1'b1;
  logic rx_drop;

  assign net_rx_ready = ~rst;
  assign rx_drop      = net_rx_valid & ~rst & (~rx_ch_ok | rx_full8[net_rx_channel]);

  // A set on the same edge as a W1C wins, so no overflow event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overflow <= '0;
      drop_cnt    <= '0;
    end else begin
      rx_overflow <= (rx_overflow & ~(clr_we ? axi_wdata[7:0] : 8'h00))
                   | (rx_drop ? (8'h01 << net_rx_channel) : 8'h00);
      if (rx_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  localparam bit DROP_EN = 1'b0;

  assign net_rx_ready = ~rst & rx_ch_ok & ~rx_full8[net_rx_channel];
  assign rx_overflow  = '0;
  assign drop_cnt     = '0;
`endif

  // ---------------- AXI decode ----------------
  assign axi_awready = ~rst & axi_awvalid & axi_wvalid & ~axi_bvalid;
  assign axi_wready  = axi_awready;
  assign aw_hs       = axi_awready;
  assign axi_arready = ~rst & ~axi_rvalid;
  assign ar_hs       = axi_arvalid & axi_arready;

  assign wr_off   = {axi_awaddr[7:2], 2'b00};
  assign wr_is_ch = axi_awaddr[7:2] < NUM_CH_W;
  assign wr_ch    = axi_awaddr[4:2];
  assign rd_off   = {axi_araddr[7:2], 2'b00};
  assign rd_is_ch = axi_araddr[7:2] < NUM_CH_W;
  assign rd_ch    = axi_araddr[4:2];

  always_comb begin
    tx_push = '0;
    wr_resp = RESP_SLVERR;
    mask_we = 1'b0;
    clr_we  = 1'b0;
    if (wr_is_ch) begin
      if (!tx_full8[wr_ch]) begin
        wr_resp = RESP_OKAY;
        for (int c = 0; c < NUM_CH; c++) tx_push[c] = aw_hs && (wr_ch == 3'(c));
      end
    end else if (wr_off == OFF_IRQ_MASK) begin
      wr_resp = RESP_OKAY;
      mask_we = aw_hs;
    end else if (wr_off == OFF_IRQ_CLEAR) begin
      wr_resp = RESP_OKAY;
      clr_we  = aw_hs;
    end
  end

  always_comb begin
    rx_pop  = '0;
    rd_resp = RESP_SLVERR;
    rd_dat  = '0;
    if (rd_is_ch) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rd_ch == 3'(c) && !rx_empty[c]) begin
          rd_resp   = RESP_OKAY;
          rd_dat    = 32'(rx_head[c]);
          rx_pop[c] = ar_hs;
        end
      end
    end else begin
      case (rd_off)
        OFF_STATUS:    begin rd_resp = RESP_OKAY; rd_dat = status_w;          end
        OFF_IRQ_MASK:  begin rd_resp = RESP_OKAY; rd_dat = {24'h0, irq_mask}; end
        OFF_IRQ_CLEAR: begin rd_resp = RESP_OKAY;                             end
        OFF_DROP_CNT: begin
          if (DROP_EN) begin
            rd_resp = RESP_OKAY;
            rd_dat  = {16'h0, drop_cnt};
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- TX arbiter ----------------
  // The output register mirrors the granted FIFO head; the entry is only
  // dequeued on transfer, so a channel being drained this cycle offers its
  // second entry to the next grant.
  assign tx_xfer  = net_tx_valid & net_tx_ready;
  assign arb_load = ~net_tx_valid | net_tx_ready;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      tx_pop[c]   = tx_xfer && (net_tx_channel == 3'(c));
      tx_avail[c] = tx_pop[c] ? tx_multi[c] : !tx_empty[c];
      tx_cand[c]  = tx_pop[c] ? tx_head2[c] : tx_head[c];
    end
  end

  always_comb begin
    arb_found = 1'b0;
    arb_ch    = '0;
    arb_pkt   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      int k;
      k = int'(rr_start) + i;
      if (k >= NUM_CH) k = k - NUM_CH;
      if (tx_avail[k]) begin
        arb_found = 1'b1;
        arb_ch    = 3'(k);
        arb_pkt   = tx_cand[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      net_tx_valid   <= 1'b0;
      net_tx_packet  <= '0;
      net_tx_channel <= '0;
      rr_start       <= '0;
    end else if (arb_load) begin
      net_tx_valid <= arb_found;
      if (arb_found) begin
        net_tx_packet  <= arb_pkt;
        net_tx_channel <= arb_ch;
        rr_start       <= (arb_ch == 3'(NUM_CH - 1)) ? 3'd0 : arb_ch + 3'd1;
      end
    end
  end

  // ---------------- responses, mask, interrupt ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      axi_bvalid    <= 1'b0;
      axi_bresp     <= '0;
      axi_rvalid    <= 1'b0;
      axi_rresp     <= '0;
      axi_rdata     <= '0;
      irq_mask      <= '0;
      cpu_interrupt <= 1'b0;
    end else begin
      if (aw_hs) begin
        axi_bvalid <= 1'b1;
        axi_bresp  <= wr_resp;
      end else if (axi_bready) begin
        axi_bvalid <= 1'b0;
      end
      if (ar_hs) begin
        axi_rvalid <= 1'b1;
        axi_rresp  <= rd_resp;
        axi_rdata  <= rd_dat;
      end else if (axi_rready) begin
        axi_rvalid <= 1'b0;
      end
      if (mask_we) irq_mask <= axi_wdata[7:0];
      cpu_interrupt <= |((rx_nonempty8 | rx_overflow) & irq_mask);
    end
  end

  assign unused_ok = ^{axi_awaddr[31:8], axi_awaddr[1:0], axi_araddr[31:8], axi_araddr[1:0],
                       axi_wstrb, axi_wdata, clr_we, rx_multi_unused};

endmodule
